// File: rtl/hex_display_scan.sv
// hex_display_scan: multiplexed common-anode hex display driver.
// Latches a packed hex word and scans NUM_DIGITS digits over a shared
// active-low segment bus. Each digit slot opens with one all-off guard cycle
// so that switching between digits does not ghost.
// oDig bit 0 is segment a and bit 6 is segment g.
// Optional feature macro: LEADING_ZERO_BLANK_EN blanks leading zero digits,
// never digit 0.
module hex_display_scan #(
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned SCAN_DIV   = 50000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic                    load,
    input  logic [NUM_DIGITS-1:0]   blank,
    output logic [6:0]              oDig,
    output logic [NUM_DIGITS-1:0]   oAn
);

    localparam int unsigned CNT_W    = $clog2(SCAN_DIV);
    localparam int unsigned IDX_W    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned SHADOW_W = 4 * NUM_DIGITS;

    logic [CNT_W-1:0]      r_cnt;
    logic [IDX_W-1:0]      r_idx;
    logic [SHADOW_W-1:0]   r_shadow;

    logic [NUM_DIGITS-1:0] w_lz;
    logic [NUM_DIGITS-1:0] w_an;
    logic [3:0]            w_nib;
    logic                  w_blank;
    logic [6:0]            w_seg_ag;
    logic [6:0]            w_seg;
    logic                  w_slot_end;

    assign w_slot_end = (r_cnt == CNT_W'(SCAN_DIV - 1));

    // Leading-zero mask: walks down from the top digit while nibbles are zero
`ifdef LEADING_ZERO_BLANK_EN
    always_comb begin
        logic v_run;
        w_lz  = '0;
        v_run = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            v_run   = v_run && (r_shadow[4*i +: 4] == 4'h0);
            w_lz[i] = v_run;
        end
    end
`else
    always_comb begin
        w_lz = '0;
    end
`endif

    // Select the active digit's nibble, blank flag and anode pattern
    always_comb begin
        w_nib   = 4'h0;
        w_blank = 1'b0;
        w_an    = '1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (r_idx == IDX_W'(i)) begin
                w_nib   = r_shadow[4*i +: 4];
                w_blank = blank[i] | w_lz[i];
                w_an[i] = 1'b0;
            end
        end
    end

    // Hex to active-low segments, written MSB=a .. LSB=g
    always_comb begin
        w_seg_ag = 7'b1111111;
        case (w_nib)
            4'h0: w_seg_ag = 7'b0000001;
            4'h1: w_seg_ag = 7'b1001111;
            4'h2: w_seg_ag = 7'b0010010;
            4'h3: w_seg_ag = 7'b0000110;
            4'h4: w_seg_ag = 7'b1001100;
            4'h5: w_seg_ag = 7'b0100100;
            4'h6: w_seg_ag = 7'b0100000;
            4'h7: w_seg_ag = 7'b0001111;
            4'h8: w_seg_ag = 7'b0000000;
            4'h9: w_seg_ag = 7'b0000100;
            4'hA: w_seg_ag = 7'b0001000;
            4'hB: w_seg_ag = 7'b1100000;
            4'hC: w_seg_ag = 7'b0110001;
            4'hD: w_seg_ag = 7'b1000010;
            4'hE: w_seg_ag = 7'b0110000;
            4'hF: w_seg_ag = 7'b0111000;
            default: w_seg_ag = 7'b1111111;
        endcase
    end

    // Reorder so that pin bit 0 carries segment a
    always_comb begin
        w_seg = '1;
        for (int i = 0; i < 7; i++) begin
            w_seg[i] = w_seg_ag[6-i];
        end
    end

    // Slot prescaler and digit index
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
            r_idx <= '0;
        end else begin
            r_cnt <= w_slot_end ? '0 : r_cnt + CNT_W'(1);
            if (w_slot_end) begin
                r_idx <= (r_idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : r_idx + IDX_W'(1);
            end
        end
    end

    // Shadow register for the displayed word
    always_ff @(posedge clk) begin
        if (reset) begin
            r_shadow <= '0;
        end else if (load) begin
            r_shadow <= value;
        end
    end

    // Registered pin drivers; cnt==0 is the all-off guard cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            oDig <= '1;
            oAn  <= '1;
        end else begin
            oAn  <= (r_cnt == '0) ? '1 : w_an;
            oDig <= w_blank ? '1 : w_seg;
        end
    end

endmodule
